// File: rtl/lfsr_checker_16bit.sv
// Receive-side PRBS checker for the 16-bit LFSR generator: self-syncs, then flywheels.
// Optional per-bit error counting is enabled with `define LFSR_CHK_BITCNT_EN.
module lfsr_checker_16bit #(
  parameter int unsigned SYNC_COUNT  = 4,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      d,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] SYNC_N = 8'(SYNC_COUNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_THRESH);

  state_t      state, state_nxt;
  logic [15:0] exp_q, exp_nxt;
  logic [7:0]  run_q, run_nxt;
  logic [7:0]  miss_q, miss_nxt;
  logic        word_err;

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], x[0] ^ x[7] ^ x[15]};
  endfunction

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_q;
    run_nxt   = run_q;
    miss_nxt  = miss_q;
    word_err  = 1'b0;
    if (en) begin
      case (state)
        SEARCH: begin
          // reseed from received data every word; zero word is never a match
          exp_nxt = nxt(d);
          if ((d == exp_q) && (d != '0)) run_nxt = run_q + 8'd1;
          else                           run_nxt = '0;
          if (run_nxt == SYNC_N) begin
            state_nxt = LOCKED;
            run_nxt   = '0;
            miss_nxt  = '0;
          end
        end
        LOCKED: begin
          exp_nxt = nxt(exp_q);
          if (d == exp_q) begin
            miss_nxt = '0;
          end else begin
            word_err = 1'b1;
            miss_nxt = miss_q + 8'd1;
            if (miss_nxt == LOSS_N) begin
              state_nxt = SEARCH;
              run_nxt   = '0;
              miss_nxt  = '0;
              exp_nxt   = nxt(d);
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_q     <= exp_nxt;
      run_q     <= run_nxt;
      miss_q    <= miss_nxt;
      err_pulse <= word_err;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_word_cnt <= '0;
    else if (clr)                          err_word_cnt <= '0;
    else if (word_err && !(&err_word_cnt)) err_word_cnt <= err_word_cnt + 1'b1;
  end

`ifdef LFSR_CHK_BITCNT_EN
  logic [4:0]       pop;
  logic [CNT_W+4:0] bit_sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 16; i++) pop = pop + {4'b0, d[i] ^ exp_q[i]};
    bit_sum = {5'b0, bit_err_cnt} + {{CNT_W{1'b0}}, pop};
  end

  // clamp whole increment at all-ones rather than wrapping the overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bit_err_cnt <= '0;
    else if (clr)    bit_err_cnt <= '0;
    else if (word_err) begin
      if (|bit_sum[CNT_W+4:CNT_W]) bit_err_cnt <= '1;
      else                         bit_err_cnt <= bit_sum[CNT_W-1:0];
    end
  end
`else
  assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker_16bit.sv
// Directed self-checking bench for lfsr_checker_16bit (default and CNT_W=4 instances).
module tb_lfsr_checker_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] d;
  logic        clr;
  logic        locked, err_pulse;
  logic [15:0] err_word_cnt, bit_err_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_word_cnt4, bit_err_cnt4;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_bits  = 0;
  logic [15:0] pred;

`ifdef LFSR_CHK_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  lfsr_checker_16bit #(.SYNC_COUNT(4), .LOSS_THRESH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .locked(locked), .err_pulse(err_pulse),
    .err_word_cnt(err_word_cnt), .bit_err_cnt(bit_err_cnt)
  );

  lfsr_checker_16bit #(.SYNC_COUNT(4), .LOSS_THRESH(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .locked(locked4), .err_pulse(err_pulse4),
    .err_word_cnt(err_word_cnt4), .bit_err_cnt(bit_err_cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], x[0] ^ x[7] ^ x[15]};
  endfunction

  task automatic step(input logic e, input logic [15:0] w, input logic c);
    en = e; d = w; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; d = '0; clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bits = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL reset_pulse got %0b want 0", err_pulse); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL reset_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== 16'd0) $display("FAIL reset_bcnt got %0d want 0", bit_err_cnt); else pass_cnt++;
  endtask

  task automatic test_sync();
    logic [15:0] words [5];
    words = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0);
      total_cnt++; if (locked !== 1'b0) $display("FAIL sync_early_lock word %0d got %0b want 0", i, locked); else pass_cnt++;
    end
    step(1'b1, words[4], 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL sync_lock got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL sync_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    pred = 16'h003F;
  endtask

  task automatic test_single_error();
    step(1'b1, 16'h003F, 1'b0);
    step(1'b1, 16'h007F, 1'b0);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL se_no_pulse got %0b want 0", err_pulse); else pass_cnt++;
    step(1'b1, 16'h00FE, 1'b0);
    exp_bits += 1;
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL se_pulse got %0b want 1", err_pulse); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd1) $display("FAIL se_wcnt got %0d want 1", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== (BITCNT ? 16'd1 : 16'd0)) $display("FAIL se_bcnt got %0d want %0d", bit_err_cnt, BITCNT); else pass_cnt++;
    step(1'b1, 16'h01FE, 1'b0);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL se_pulse_end got %0b want 0", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL se_locked got %0b want 1", locked); else pass_cnt++;
    pred = 16'h03FD;
  endtask

  task automatic test_loss_relock();
    logic [15:0] garb [3];
    logic [15:0] s;
    garb = '{16'h1234, 16'h5678, 16'h9ABC};
    for (int i = 0; i < 3; i++) begin
      exp_bits += $countones(garb[i] ^ pred);
      pred = nxt(pred);
      step(1'b1, garb[i], 1'b0);
      total_cnt++; if (err_pulse !== 1'b1) $display("FAIL loss_pulse %0d got %0b want 1", i, err_pulse); else pass_cnt++;
      total_cnt++; if (locked !== (i < 2)) $display("FAIL loss_locked %0d got %0b want %0b", i, locked, i < 2); else pass_cnt++;
    end
    total_cnt++; if (err_word_cnt !== 16'd4) $display("FAIL loss_wcnt got %0d want 4", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== (BITCNT ? 16'(exp_bits) : 16'd0)) $display("FAIL loss_bcnt got %0d want %0d", bit_err_cnt, BITCNT ? exp_bits : 0); else pass_cnt++;
    s = 16'h0ACE;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s, 1'b0);
      s = nxt(s);
      total_cnt++; if (locked !== 1'b0) $display("FAIL relock_early %0d got %0b want 0", i, locked); else pass_cnt++;
    end
    step(1'b1, s, 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL relock got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd4) $display("FAIL relock_wcnt got %0d want 4", err_word_cnt); else pass_cnt++;
  endtask

  task automatic test_zero_stream();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0000, 1'b0);
      total_cnt++; if (locked !== 1'b0) $display("FAIL zero_locked %0d got %0b want 0", i, locked); else pass_cnt++;
    end
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL zero_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== 16'd0) $display("FAIL zero_bcnt got %0d want 0", bit_err_cnt); else pass_cnt++;
  endtask

  task automatic sync_from_one();
    pred = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pred, 1'b0);
      pred = nxt(pred);
    end
    total_cnt++; if (locked !== 1'b1) $display("FAIL sync1_lock got %0b want 1", locked); else pass_cnt++;
  endtask

  task automatic test_en_gap_clr();
    do_reset();
    sync_from_one();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'hDEAD, 1'b0);
      total_cnt++; if (locked !== 1'b1) $display("FAIL gap_locked %0d got %0b want 1", i, locked); else pass_cnt++;
      total_cnt++; if (err_pulse !== 1'b0) $display("FAIL gap_pulse %0d got %0b want 0", i, err_pulse); else pass_cnt++;
    end
    step(1'b1, pred, 1'b0);
    pred = nxt(pred);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL gap_resume_pulse got %0b want 0", err_pulse); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL gap_resume_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    step(1'b1, pred ^ 16'h0101, 1'b0);
    pred = nxt(pred);
    total_cnt++; if (err_word_cnt !== 16'd1) $display("FAIL pre_clr_wcnt got %0d want 1", err_word_cnt); else pass_cnt++;
    step(1'b1, pred ^ 16'h0001, 1'b1);
    pred = nxt(pred);
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL clr_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== 16'd0) $display("FAIL clr_bcnt got %0d want 0", bit_err_cnt); else pass_cnt++;
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL clr_pulse got %0b want 1", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL clr_locked got %0b want 1", locked); else pass_cnt++;
  endtask

  task automatic test_saturation_rst();
    do_reset();
    sync_from_one();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pred, 1'b0);
      pred = nxt(pred);
      step(1'b1, pred ^ 16'h8000, 1'b0);
      pred = nxt(pred);
    end
    total_cnt++; if (locked4 !== 1'b1) $display("FAIL sat_locked got %0b want 1", locked4); else pass_cnt++;
    total_cnt++; if (err_word_cnt4 !== 4'd15) $display("FAIL sat_wcnt4 got %0d want 15", err_word_cnt4); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd20) $display("FAIL sat_wcnt16 got %0d want 20", err_word_cnt); else pass_cnt++;
    total_cnt++; if (bit_err_cnt4 !== (BITCNT ? 4'd15 : 4'd0)) $display("FAIL sat_bcnt4 got %0d want %0d", bit_err_cnt4, BITCNT ? 15 : 0); else pass_cnt++;
    total_cnt++; if (bit_err_cnt !== (BITCNT ? 16'd20 : 16'd0)) $display("FAIL sat_bcnt16 got %0d want %0d", bit_err_cnt, BITCNT ? 20 : 0); else pass_cnt++;
    rst = 1'b1;
    #2;
    total_cnt++; if (locked !== 1'b0) $display("FAIL arst_locked got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 16'd0) $display("FAIL arst_wcnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt4 !== 4'd0) $display("FAIL arst_wcnt4 got %0d want 0", err_word_cnt4); else pass_cnt++;
    total_cnt++; if (bit_err_cnt4 !== 4'd0) $display("FAIL arst_bcnt4 got %0d want 0", bit_err_cnt4); else pass_cnt++;
    rst = 1'b0;
    // after reset, the flywheel seed is gone: words from the old stream need a full resync
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pred, 1'b0);
      pred = nxt(pred);
    end
    total_cnt++; if (locked !== 1'b0) $display("FAIL arst_relock_early got %0b want 0", locked); else pass_cnt++;
    step(1'b1, pred, 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL arst_relock got %0b want 1", locked); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = '0; clr = 1'b0;
    #2;
    test_reset();
    test_sync();
    test_single_error();
    test_loss_relock();
    test_zero_stream();
    test_en_gap_clr();
    test_saturation_rst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
